// File: rtl/fetch_queue_pkg.sv
// Shared types and FSM encodings for the instruction prefetch queue.
// FetchEntry_t is the default 32-bit {pc, inst} pair that travels to decode.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] Inst_t;
  typedef logic [XLEN-1:0] Inst_addr_t;

  typedef struct packed {
    Inst_addr_t pc;
    Inst_t      inst;
  } FetchEntry_t;

  localparam logic [0:0] FETCH_RUN   = 1'b0;
  localparam logic [0:0] FETCH_DRAIN = 1'b1;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus plus the decode-side valid/ready port.
// master is the prefetch unit; slave is whoever models memory and decode.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = XLEN,
  parameter int unsigned DATA_W = XLEN
);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              out_valid_o;
  logic [ADDR_W-1:0] out_pc_o;
  logic [DATA_W-1:0] out_inst_o;
  logic              out_ready_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output out_valid_o, out_pc_o, out_inst_o,
    input  out_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  out_valid_o, out_pc_o, out_inst_o,
    output out_ready_i
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Plain synchronous FIFO with push/pop/clear; no handshake logic of its own.
// The head reads as zero while empty so downstream never sees stale entries.
module fetch_queue_sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = FetchEntry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output entry_t                     head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            popEn, pushEn;

  assign popEn  = pop_i && (count_q != '0);
  assign pushEn = push_i && ((count_q != CW'(DEPTH)) || popEn);

  // Clear snaps the read pointer onto the write pointer rather than zeroing both.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (clear_i) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PW'(1);
      if (popEn)  rdPtr_d = rdPtr_q + PW'(1);
      if (pushEn && !popEn) count_d = count_q + CW'(1);
      if (popEn && !pushEn) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_i && pushEn) mem_q[wrPtr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rdPtr_q] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: issues sequential fetches under a credit limit,
// buffers in-order responses and squashes in-flight ones after a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d, respPc_q, respPc_d;
  logic [OW-1:0]     outstanding_q, outstanding_d, killCnt_q, killCnt_d;
  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     fifoCount;
  logic              haveCredit, grant, pushEn, popEn;
  entry_t            pushData, headEntry;

  // Credit uses only registered terms, so a pop frees space one cycle later.
  assign haveCredit = ((32'(outstanding_q) - 32'(killCnt_q) + 32'(fifoCount)) < 32'(DEPTH))
                      && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));

  assign bus.mem_req_o  = !rst && !redirect_i && haveCredit;
  assign bus.mem_addr_o = fetchPc_q;
  assign grant          = bus.mem_req_o && bus.mem_gnt_i;

  assign pushEn   = bus.mem_rvalid_i && (state_q == FETCH_RUN) && !redirect_i;
  assign popEn    = bus.out_valid_o && bus.out_ready_i && !redirect_i;
  assign pushData = {respPc_q, bus.mem_rdata_i};

  // On redirect every response still owed, except one landing now, must be dropped.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    killCnt_d     = killCnt_q;
    outstanding_d = outstanding_q + OW'(grant) - OW'(bus.mem_rvalid_i);
    if (grant)  fetchPc_d = fetchPc_q + ADDR_W'(4);
    if (pushEn) respPc_d  = respPc_q + ADDR_W'(4);
    if (bus.mem_rvalid_i && (state_q == FETCH_DRAIN)) killCnt_d = killCnt_q - OW'(1);
    if (redirect_i) begin
      fetchPc_d = redirect_pc_i;
      respPc_d  = redirect_pc_i;
      killCnt_d = outstanding_q - OW'(bus.mem_rvalid_i);
    end
    state_d = (killCnt_d != '0) ? FETCH_DRAIN : FETCH_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      outstanding_q <= '0;
      killCnt_q     <= '0;
      state_q       <= FETCH_RUN;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      killCnt_q     <= killCnt_d;
      state_q       <= state_d;
    end
  end

  fetch_queue_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pushEn),
    .push_data_i (pushData),
    .pop_i       (popEn),
    .clear_i     (redirect_i),
    .count_o     (fifoCount),
    .head_o      (headEntry)
  );

  assign bus.out_valid_o = (fifoCount != '0);
  assign bus.out_pc_o    = headEntry.pc;
  assign bus.out_inst_o  = headEntry.inst;
  assign count_o         = fifoCount;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order memory responder plus a
// scoreboard of expected {pc, inst} entries checked every cycle.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    bit          live;
  } Pend_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [2:0]  count;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .bus(bus), .count_o(count)
  );

  always #5 clk = ~clk;

  Pend_t       pending[$];
  FetchEntry_t model[$];
  logic [31:0] expPc;
  bit          gntEn, respEn, readyEn;
  int          checks = 0;
  int          failures = 0;
  int          grants, n, firstValid;
  logic        sReq, sValid;
  logic [31:0] sAddr, sPc, sInst, savedAddr;
  logic [2:0]  sCount;
  bit          popped;
  FetchEntry_t poppedEntry;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Memory returns responses in order, one cycle after the grant at the earliest.
  task automatic applyStimulus();
    bus.mem_gnt_i   = gntEn;
    bus.out_ready_i = readyEn;
    if (!rst && respEn && pending.size() > 0) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = instOf(pending[0].addr);
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
    end
  endtask

  task automatic checkOutput();
    int livePend;
    bit expReq;
    livePend = 0;
    sReq   = bus.mem_req_o;
    sAddr  = bus.mem_addr_o;
    sValid = bus.out_valid_o;
    sPc    = bus.out_pc_o;
    sInst  = bus.out_inst_o;
    sCount = count;
    foreach (pending[i]) if (pending[i].live) livePend++;
    if (rst) begin
      check("req_in_reset", sReq, 0);
      return;
    end
    expReq = !redirect && ((livePend + model.size()) < DEPTH) && (pending.size() < MAXO);
    check("mem_req", sReq, expReq);
    if (expReq) check("mem_addr", sAddr, expPc);
    check("count", sCount, model.size());
    check("out_valid", sValid, model.size() != 0);
    if (model.size() != 0) begin
      check("out_pc", sPc, model[0].pc);
      check("out_inst", sInst, model[0].inst);
    end else begin
      check("out_pc_empty", sPc, 0);
      check("out_inst_empty", sInst, 0);
    end
    check("outstanding_bound", pending.size() <= MAXO, 1);
  endtask

  task automatic updateModel();
    Pend_t       p;
    FetchEntry_t e;
    popped = 0;
    if (rst) begin
      pending.delete();
      model.delete();
      expPc = RESET_PC;
      return;
    end
    if (readyEn && !redirect && model.size() != 0) begin
      poppedEntry = model.pop_front();
      popped = 1;
    end
    if (bus.mem_rvalid_i) begin
      p = pending.pop_front();
      if (p.live && !redirect) begin
        e.pc   = p.addr;
        e.inst = instOf(p.addr);
        model.push_back(e);
      end
    end
    if (sReq && gntEn) begin
      p.addr = sAddr;
      p.live = 1'b1;
      pending.push_back(p);
      expPc = expPc + 32'd4;
      grants++;
    end
    if (redirect) begin
      foreach (pending[i]) pending[i].live = 1'b0;
      model.delete();
      expPc = redirectPc;
    end
  endtask

  task automatic cycle();
    applyStimulus();
    #1;
    checkOutput();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirectPc = '0;
    gntEn = 0; respEn = 0; readyEn = 0; grants = 0; expPc = RESET_PC;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.out_ready_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset_valid", bus.out_valid_o, 0);
    check("reset_count", count, 0);
    check("reset_out_pc", bus.out_pc_o, 0);
    check("reset_req", bus.mem_req_o, 0);
    cycle();
    rst = 1'b0;

    $display("[TB] streaming from reset");
    gntEn = 1; respEn = 1; readyEn = 1; firstValid = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 0) check("first_req_addr", sAddr, RESET_PC);
      if (sValid && firstValid < 0) begin
        firstValid = i;
        check("first_out_pc", sPc, RESET_PC);
      end
    end
    check("first_valid_cycle", firstValid, 2);

    $display("[TB] stall with decode not ready");
    gntEn = 0; n = 0;
    while ((pending.size() != 0 || model.size() != 0) && n < 10) begin cycle(); n++; end
    check("drain_done", pending.size() + model.size(), 0);
    gntEn = 1; readyEn = 0; grants = 0;
    repeat (10) cycle();
    check("stall_grants", grants, 4);
    check("stall_count", sCount, 4);
    check("stall_req_low", sReq, 0);
    readyEn = 1; grants = 0;
    repeat (8) cycle();
    check("fetch_resumed", grants != 0, 1);

    $display("[TB] redirect with two requests in flight");
    respEn = 0; n = 0;
    while (pending.size() != MAXO && n < 10) begin cycle(); n++; end
    check("two_in_flight", pending.size(), MAXO);
    redirect = 1; redirectPc = 32'h8000_1000;
    cycle();
    redirect = 0; respEn = 1; n = 0;
    do begin cycle(); n++; end while (!popped && n < 20);
    check("redir1_pop_seen", popped, 1);
    check("redir1_first_pc", poppedEntry.pc, 32'h8000_1000);
    check("redir1_first_inst", poppedEntry.inst, instOf(32'h8000_1000));

    $display("[TB] redirect coinciding with a response");
    respEn = 0; n = 0;
    while (pending.size() != MAXO && n < 10) begin cycle(); n++; end
    check("two_in_flight_b", pending.size(), MAXO);
    respEn = 1; redirect = 1; redirectPc = 32'h8000_2000;
    cycle();
    redirect = 0; n = 0;
    do begin cycle(); n++; end while (!popped && n < 20);
    check("redir2_pop_seen", popped, 1);
    check("redir2_first_pc", poppedEntry.pc, 32'h8000_2000);
    check("redir2_first_inst", poppedEntry.inst, instOf(32'h8000_2000));

    $display("[TB] grant withheld");
    gntEn = 0;
    repeat (4) cycle();
    savedAddr = sAddr;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_req", sReq, 1);
      check("hold_addr", sAddr, savedAddr);
    end
    gntEn = 1;
    cycle();
    cycle();
    check("post_grant_req", sReq, 1);
    check("post_grant_addr", sAddr, savedAddr + 32'd4);

    $display("[TB] reset mid-stream");
    readyEn = 0; n = 0;
    while (model.size() < 2 && n < 20) begin cycle(); n++; end
    check("partial_fill", model.size() >= 2, 1);
    respEn = 0; n = 0;
    while (pending.size() != MAXO && n < 10) begin cycle(); n++; end
    check("two_in_flight_c", pending.size(), MAXO);
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    check("post_reset_count", sCount, 0);
    check("post_reset_req", sReq, 1);
    check("post_reset_addr", sAddr, RESET_PC);
    readyEn = 1; respEn = 1;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
